issue_unit: RTL and testbench

- Dual-issue in-order issue stage directly downstream of the instruction buffer.
- Each cycle it inspects the two head entries, resolves hazards against a register scoreboard and a divider-occupancy counter, and returns o_size (0/1/2) to the buffer.
- Issued entries go into a registered EX-stage slot pair.
- Serializing instructions (CSR, exceptions) drain the pipeline and issue alone.

---
 rtl/issue_unit_pkg.sv | 40 ++++
 rtl/issue_scoreboard.sv | 55 +++++
 rtl/issue_unit.sv | 148 ++++++++++++++
 tb/tb_issue_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_unit_pkg.sv
// Shared types for the dual-issue stage: buffer entry layout,
// functional-unit classes and issue FSM states.
package issue_unit_pkg;

  typedef enum logic [2:0] {
    OP_ALU,
    OP_BRU,
    OP_MUL,
    OP_DIV,
    OP_MEM,
    OP_CSR
  } optype_t;

  typedef struct packed {
    logic [31:0] pc;
    optype_t     optype;
    logic [6:0]  opcode;
    logic [4:0]  dest;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        src2_is_imm;
    logic        have_excp;
    logic        csr_wr;
  } issue_entry_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SOLO
  } iss_state_t;

  function automatic logic is_serial(issue_entry_t e);
    return (e.optype == OP_CSR) || e.have_excp;
  endfunction

  function automatic logic is_muldiv(issue_entry_t e);
    return (e.optype == OP_MUL) || (e.optype == OP_DIV);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy tracking with writeback bypass; answers "is this
// register free" for every source and destination queried.
module issue_scoreboard
  import issue_unit_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NQ   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                set_a_en_i,
  input  logic [4:0]          set_a_dest_i,
  input  logic                set_b_en_i,
  input  logic [4:0]          set_b_dest_i,
  input  logic                wb_a_en_i,
  input  logic [4:0]          wb_a_dest_i,
  input  logic                wb_b_en_i,
  input  logic [4:0]          wb_b_dest_i,
  input  logic [NQ-1:0][4:0]  q_reg_i,
  output logic [NQ-1:0]       q_free_o,
  output logic                idle_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wb_a_en_i) busy_d[wb_a_dest_i] = 1'b0;
    if (wb_b_en_i) busy_d[wb_b_dest_i] = 1'b0;
    // issue sets are applied last so a same-cycle set beats a clear
    if (set_a_en_i) busy_d[set_a_dest_i] = 1'b1;
    if (set_b_en_i) busy_d[set_b_dest_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) busy_q <= '0;
    else                  busy_q <= busy_d;
  end

  always_comb begin
    q_free_o = '0;
    for (int i = 0; i < NQ; i++) begin
      q_free_o[i] = (q_reg_i[i] == 5'd0)
                  || !busy_q[q_reg_i[i]]
                  || (wb_a_en_i && (wb_a_dest_i == q_reg_i[i]))
                  || (wb_b_en_i && (wb_b_dest_i == q_reg_i[i]));
    end
  end

  assign idle_o = ~|busy_q;

endmodule

// File: rtl/issue_unit.sv
// In-order dual-issue stage: picks 0/1/2 buffer head entries per
// cycle and registers them into the EX slot pair.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int DIV_LAT = 8,
  parameter int NREG    = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         i_a_valid,
  input  issue_entry_t i_a_entry,
  input  logic         i_b_valid,
  input  issue_entry_t i_b_entry,
  output logic [1:0]   o_size,
  input  logic         ex_stall,
  output logic         ex_a_valid,
  output issue_entry_t ex_a_entry,
  output logic         ex_b_valid,
  output issue_entry_t ex_b_entry,
  input  logic         wb_a_en,
  input  logic [4:0]   wb_a_dest,
  input  logic         wb_b_en,
  input  logic [4:0]   wb_b_dest,
  input  logic         serial_done
);

  localparam int DW = $clog2(DIV_LAT + 1);

  iss_state_t    state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;

  logic [5:0][4:0] q_reg;
  logic [5:0]      q_free;
  logic            sb_idle;

  logic a_ser, b_ser, go, div_free, ex_empty;
  logic a_ok, ser_ok, b_raw, b_ok;
  logic iss_a, iss_b;

  assign q_reg = {i_b_entry.dest, i_b_entry.r2, i_b_entry.r1,
                  i_a_entry.dest, i_a_entry.r2, i_a_entry.r1};

  issue_scoreboard #(
    .NREG (NREG),
    .NQ   (6)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush),
    .set_a_en_i   (iss_a),
    .set_a_dest_i (i_a_entry.dest),
    .set_b_en_i   (iss_b),
    .set_b_dest_i (i_b_entry.dest),
    .wb_a_en_i    (wb_a_en),
    .wb_a_dest_i  (wb_a_dest),
    .wb_b_en_i    (wb_b_en),
    .wb_b_dest_i  (wb_b_dest),
    .q_reg_i      (q_reg),
    .q_free_o     (q_free),
    .idle_o       (sb_idle)
  );

  assign a_ser    = is_serial(i_a_entry);
  assign b_ser    = is_serial(i_b_entry);
  assign go       = !ex_stall && !flush && !reset;
  assign div_free = (div_cnt_q == '0);
  assign ex_empty = !ex_a_valid && !ex_b_valid;

  assign ser_ok = (state_q != SOLO) && sb_idle
               && div_free && ex_empty;

  assign a_ok = (state_q == RUN)
             && q_free[0]
             && (q_free[1] || i_a_entry.src2_is_imm)
             && q_free[2]
             && ((i_a_entry.optype != OP_DIV) || div_free);

  assign iss_a = go && i_a_valid && (a_ser ? ser_ok : a_ok);

  // B reading A's result cannot be bypassed within the pair
  assign b_raw = (i_a_entry.dest != 5'd0)
              && ((i_b_entry.r1 == i_a_entry.dest)
               || (!i_b_entry.src2_is_imm
                   && (i_b_entry.r2 == i_a_entry.dest)));

  assign b_ok = !a_ser && !b_ser && !b_raw
             && q_free[3]
             && (q_free[4] || i_b_entry.src2_is_imm)
             && q_free[5]
             && (i_b_entry.dest != i_a_entry.dest)
             && !((i_a_entry.optype == OP_MEM)
               && (i_b_entry.optype == OP_MEM))
             && !(is_muldiv(i_a_entry) && is_muldiv(i_b_entry))
             && (i_a_entry.optype != OP_BRU)
             && ((i_b_entry.optype != OP_DIV) || div_free);

  assign iss_b = iss_a && i_b_valid && b_ok;

  assign o_size = iss_b ? 2'd2 : (iss_a ? 2'd1 : 2'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (iss_a && a_ser)          state_d = SOLO;
        else if (i_a_valid && a_ser) state_d = DRAIN;
      end
      DRAIN: if (iss_a)       state_d = SOLO;
      SOLO:  if (serial_done) state_d = RUN;
      default:                state_d = RUN;
    endcase
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if ((iss_a && (i_a_entry.optype == OP_DIV))
        || (iss_b && (i_b_entry.optype == OP_DIV)))
      div_cnt_d = DW'(DIV_LAT);
    else if (!div_free)
      div_cnt_d = div_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q    <= RUN;
      div_cnt_q  <= '0;
      ex_a_valid <= 1'b0;
      ex_b_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      if (!ex_stall) begin
        ex_a_valid <= iss_a;
        ex_b_valid <= iss_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!ex_stall) begin
      ex_a_entry <= i_a_entry;
      ex_b_entry <= i_b_entry;
    end
  end

endmodule

// File: tb/tb_issue_unit.sv
// Directed plus buffer-driven random stimulus for issue_unit,
// checked against a rule-level reference model.
module tb_issue_unit;
  import issue_unit_pkg::*;

  localparam int DIV_LAT = 8;

  logic         clk = 1'b0;
  logic         reset, flush, ex_stall, sdone;
  logic         a_v, b_v, exa_v, exb_v;
  issue_entry_t a_e, b_e, exa_e, exb_e;
  logic         wba_en, wbb_en;
  logic [4:0]   wba_d, wbb_d;
  logic [1:0]   osz;

  int total = 0;
  int bad   = 0;

  bit           mbusy [32];
  int           mdiv;
  int           mmode;
  bit           m_exa, m_exb;
  issue_entry_t m_ea, m_eb;
  int           exp_sz;
  issue_entry_t q [$];

  issue_unit #(.DIV_LAT(DIV_LAT), .NREG(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .i_a_valid   (a_v),
    .i_a_entry   (a_e),
    .i_b_valid   (b_v),
    .i_b_entry   (b_e),
    .o_size      (osz),
    .ex_stall    (ex_stall),
    .ex_a_valid  (exa_v),
    .ex_a_entry  (exa_e),
    .ex_b_valid  (exb_v),
    .ex_b_entry  (exb_e),
    .wb_a_en     (wba_en),
    .wb_a_dest   (wba_d),
    .wb_b_en     (wbb_en),
    .wb_b_dest   (wbb_d),
    .serial_done (sdone)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic issue_entry_t mk(optype_t o, int d, int r1,
                                      int r2, bit imm);
    issue_entry_t e;
    e = '0;
    e.pc          = $urandom;
    e.optype      = o;
    e.opcode      = 7'($urandom);
    e.dest        = 5'(d);
    e.r1          = 5'(r1);
    e.r2          = 5'(r2);
    e.src2_is_imm = imm;
    return e;
  endfunction

  function automatic issue_entry_t rnd_entry();
    issue_entry_t e;
    int r;
    r = $urandom_range(0, 19);
    e = mk(r == 0 ? OP_CSR : optype_t'(r % 5),
           $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), 1'($urandom));
    e.have_excp = ($urandom_range(0, 39) == 0);
    e.csr_wr    = 1'($urandom);
    return e;
  endfunction

  function automatic bit ser(issue_entry_t e);
    return e.optype == OP_CSR || e.have_excp;
  endfunction

  function automatic bit md(issue_entry_t e);
    return e.optype == OP_MUL || e.optype == OP_DIV;
  endfunction

  function automatic bit mfree(logic [4:0] r);
    return r == 0 || !mbusy[r]
        || (wba_en && wba_d == r) || (wbb_en && wbb_d == r);
  endfunction

  function automatic bit srcs_ok(issue_entry_t e);
    return mfree(e.r1) && (e.src2_is_imm || mfree(e.r2))
        && mfree(e.dest);
  endfunction

  function automatic logic [31:0] mvec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic int model_size();
    if (reset || flush || ex_stall || !a_v || mmode == 2) return 0;
    if (ser(a_e))
      return (mvec() == 0 && mdiv == 0 && !m_exa && !m_exb) ? 1 : 0;
    if (mmode != 0) return 0;
    if (!srcs_ok(a_e)) return 0;
    if (a_e.optype == OP_DIV && mdiv != 0) return 0;
    if (!b_v || ser(b_e) || a_e.optype == OP_BRU) return 1;
    if (!srcs_ok(b_e)) return 1;
    if (a_e.dest != 0 && (b_e.r1 == a_e.dest
        || (!b_e.src2_is_imm && b_e.r2 == a_e.dest))) return 1;
    if (b_e.dest == a_e.dest) return 1;
    if (a_e.optype == OP_MEM && b_e.optype == OP_MEM) return 1;
    if (md(a_e) && md(b_e)) return 1;
    if (b_e.optype == OP_DIV && mdiv != 0) return 1;
    return 2;
  endfunction

  task automatic model_update(int n);
    if (reset || flush) begin
      foreach (mbusy[i]) mbusy[i] = 0;
      mdiv  = 0;
      mmode = 0;
      m_exa = 0;
      m_exb = 0;
      return;
    end
    if (wba_en) mbusy[wba_d] = 0;
    if (wbb_en) mbusy[wbb_d] = 0;
    if (n >= 1 && a_e.dest != 0) mbusy[a_e.dest] = 1;
    if (n == 2 && b_e.dest != 0) mbusy[b_e.dest] = 1;
    if ((n >= 1 && a_e.optype == OP_DIV)
        || (n == 2 && b_e.optype == OP_DIV)) mdiv = DIV_LAT;
    else if (mdiv > 0) mdiv--;
    if (mmode == 2) begin
      if (sdone) mmode = 0;
    end else if (n > 0 && ser(a_e)) mmode = 2;
    else if (mmode == 0 && a_v && ser(a_e)) mmode = 1;
    if (!ex_stall) begin
      m_exa = (n >= 1);
      m_exb = (n == 2);
      m_ea  = a_e;
      m_eb  = b_e;
    end
  endtask

  function automatic iss_state_t mstate();
    case (mmode)
      1:       return DRAIN;
      2:       return SOLO;
      default: return RUN;
    endcase
  endfunction

  task automatic cyc(int want = -1);
    #1;
    exp_sz = model_size();
    chk("o_size", osz, exp_sz);
    if (want >= 0) chk("o_size_plan", osz, want);
    @(posedge clk);
    model_update(exp_sz);
    #1;
    chk("ex_a_valid", exa_v, m_exa);
    chk("ex_b_valid", exb_v, m_exb);
    if (m_exa) chk("ex_a_entry", exa_e, m_ea);
    if (m_exb) chk("ex_b_entry", exb_e, m_eb);
    chk("busy", dut.u_sb.busy_q, mvec());
    chk("div_cnt", 64'(dut.div_cnt_q), mdiv);
    chk("state", dut.state_q, mstate());
  endtask

  task automatic quiet();
    a_v = 0; b_v = 0; wba_en = 0; wbb_en = 0;
    flush = 0; ex_stall = 0; sdone = 0;
  endtask

  initial begin
    issue_entry_t csr, alu;
    foreach (mbusy[i]) mbusy[i] = 0;
    mdiv = 0; mmode = 0; m_exa = 0; m_exb = 0;
    a_e = '0; b_e = '0; wba_d = 0; wbb_d = 0;
    quiet();
    reset = 1;
    cyc(0);
    reset = 0;
    cyc(0);

    // independent ALU pair
    a_e = mk(OP_ALU, 3, 1, 2, 0); a_v = 1;
    b_e = mk(OP_ALU, 5, 4, 0, 1); b_v = 1;
    cyc(2);
    chk("pair_exb", exb_v, 1);
    chk("busy3", dut.u_sb.busy_q[3], 1);
    chk("busy5", dut.u_sb.busy_q[5], 1);
    quiet();
    wba_en = 1; wba_d = 3; wbb_en = 1; wbb_d = 5;
    cyc();

    // RAW within the pair, then bypass
    quiet();
    a_e = mk(OP_ALU, 3, 1, 2, 0); a_v = 1;
    b_e = mk(OP_ALU, 6, 3, 0, 1); b_v = 1;
    cyc(1);
    a_e = b_e; b_v = 0;
    cyc(0);
    wba_en = 1; wba_d = 3;
    cyc(1);
    quiet();
    wbb_en = 1; wbb_d = 6;
    cyc();

    // WAW, released by writeback; set beats clear
    quiet();
    a_e = mk(OP_ALU, 7, 0, 0, 1); a_v = 1;
    cyc(1);
    a_e = mk(OP_ALU, 7, 1, 0, 1);
    cyc(0);
    cyc(0);
    wbb_en = 1; wbb_d = 7;
    cyc(1);
    chk("busy7_set_wins", dut.u_sb.busy_q[7], 1);
    quiet();
    wba_en = 1; wba_d = 7;
    cyc();

    // divider occupancy
    quiet();
    a_e = mk(OP_DIV, 9, 1, 2, 0); a_v = 1;
    cyc(1);
    a_e = mk(OP_DIV, 10, 1, 2, 0);
    for (int i = 0; i < DIV_LAT; i++) begin
      wba_en = (i == 0); wba_d = 9;
      cyc(0);
    end
    wba_en = 0;
    cyc(1);
    quiet();
    wba_en = 1; wba_d = 10;
    cyc();
    wba_en = 0;
    repeat (DIV_LAT) cyc();

    // CSR drains the pipe and issues alone
    a_e = mk(OP_ALU, 4, 0, 0, 1); a_v = 1;
    cyc(1);
    csr = mk(OP_CSR, 0, 1, 0, 1);
    alu = mk(OP_ALU, 11, 1, 0, 1);
    a_e = csr; b_e = alu; b_v = 1;
    cyc(0);
    chk("state_drain", dut.state_q, DRAIN);
    cyc(0);
    wba_en = 1; wba_d = 4;
    cyc(0);
    wba_en = 0;
    cyc(1);
    chk("state_solo", dut.state_q, SOLO);
    a_e = alu; b_v = 0;
    cyc(0);
    cyc(0);
    sdone = 1;
    cyc(0);
    sdone = 0;
    cyc(1);
    quiet();
    wba_en = 1; wba_d = 11;
    cyc();

    // flush while draining with EX stalled
    quiet();
    a_e = mk(OP_DIV, 12, 1, 2, 0); a_v = 1;
    cyc(1);
    a_e = csr; ex_stall = 1;
    cyc(0);
    chk("drain_hold_exa", exa_v, 1);
    flush = 1;
    cyc(0);
    chk("flush_exa", exa_v, 0);
    chk("flush_exb", exb_v, 0);
    chk("flush_busy", dut.u_sb.busy_q, 0);
    chk("flush_state", dut.state_q, RUN);
    chk("flush_div", 64'(dut.div_cnt_q), 0);
    quiet();
    cyc(0);

    // buffer-driven random traffic
    for (int n = 0; n < 600; n++) begin
      int busy_l [$];
      while (q.size() < 4) q.push_back(rnd_entry());
      a_v = 1; a_e = q[0];
      b_v = 1; b_e = q[1];
      foreach (mbusy[i]) if (mbusy[i]) busy_l.push_back(i);
      wba_en = 0; wbb_en = 0;
      if (busy_l.size() > 0 && $urandom_range(0, 1) == 1) begin
        wba_en = 1;
        wba_d  = 5'(busy_l[$urandom_range(0, busy_l.size() - 1)]);
      end
      if (busy_l.size() > 0 && $urandom_range(0, 2) == 0) begin
        wbb_en = 1;
        wbb_d  = 5'(busy_l[$urandom_range(0, busy_l.size() - 1)]);
      end
      ex_stall = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      sdone    = ($urandom_range(0, 4) == 0);
      cyc();
      if (flush) q.delete();
      else repeat (exp_sz) void'(q.pop_front());
    end

    quiet();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
